// File: rtl/div19sx8s.sv
// Signed 19-bit / 8-bit restoring divider, one quotient bit per clock, truncating toward zero.
// Latency: done pulses 20 cycles after the accepting start edge; next start is accepted in the done cycle.
// Backpressure: one operation in flight; start while busy is ignored and operands are not sampled.
module div19sx8s (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [18:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [18:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [18:0] dvd_sh_q, dvd_sh_d;
    logic [7:0]  dsr_mag_q, dsr_mag_d;
    logic [7:0]  r_q, r_d;
    logic [18:0] qm_q, qm_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_case_q, dz_case_d;
    logic        ovf_case_q, ovf_case_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [18:0] quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        div_zero_q, div_zero_d;
    logic        ovf_q, ovf_d;

    logic [8:0]  r_sh;
    logic [8:0]  r_diff;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_sh_d    = dvd_sh_q;
        dsr_mag_d   = dsr_mag_q;
        r_d         = r_q;
        qm_d        = qm_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_case_d   = dz_case_q;
        ovf_case_d  = ovf_case_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;
        r_sh        = {r_q, dvd_sh_q[18]};
        r_diff      = r_sh - {1'b0, dsr_mag_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Magnitudes are taken unsigned so the most negative operands map cleanly.
                    dvd_sh_d   = dividend[18] ? (~dividend + 19'd1) : dividend;
                    dsr_mag_d  = divisor[7] ? (~divisor + 8'd1) : divisor;
                    q_neg_d    = dividend[18] ^ divisor[7];
                    r_neg_d    = dividend[18];
                    dz_case_d  = (divisor == 8'h00);
                    ovf_case_d = (dividend == 19'h40000) && (divisor == 8'hFF);
                    r_d        = 8'h00;
                    qm_d       = 19'h00000;
                    cnt_d      = 5'd18;
                    busy_d     = 1'b1;
                    state_d    = S_DIV;
                end
            end

            S_DIV: begin
                // r_q < |divisor| <= 128 keeps r_sh below 256, so r_diff[8] is a clean borrow.
                if (!r_diff[8]) begin
                    r_d  = r_diff[7:0];
                    qm_d = {qm_q[17:0], 1'b1};
                end else begin
                    r_d  = r_sh[7:0];
                    qm_d = {qm_q[17:0], 1'b0};
                end
                dvd_sh_d = {dvd_sh_q[17:0], 1'b0};
                if (cnt_q == 5'd0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            S_FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dz_case_q) begin
                    quotient_d  = 19'h00000;
                    remainder_d = 8'h00;
                    div_zero_d  = 1'b1;
                    ovf_d       = 1'b0;
                end else if (ovf_case_q) begin
                    quotient_d  = 19'h3FFFF;
                    remainder_d = 8'h00;
                    div_zero_d  = 1'b0;
                    ovf_d       = 1'b1;
                end else begin
                    // Negating a zero magnitude yields zero, so no sign appears on a zero result.
                    quotient_d  = q_neg_q ? (~qm_q + 19'd1) : qm_q;
                    remainder_d = r_neg_q ? (~r_q + 8'd1) : r_q;
                    div_zero_d  = 1'b0;
                    ovf_d       = 1'b0;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            dvd_sh_q    <= 19'h00000;
            dsr_mag_q   <= 8'h00;
            r_q         <= 8'h00;
            qm_q        <= 19'h00000;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_case_q   <= 1'b0;
            ovf_case_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 19'h00000;
            remainder_q <= 8'h00;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_sh_q    <= dvd_sh_d;
            dsr_mag_q   <= dsr_mag_d;
            r_q         <= r_d;
            qm_q        <= qm_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_case_q   <= dz_case_d;
            ovf_case_q  <= ovf_case_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_div19sx8s.sv
// Directed-vector bench for div19sx8s: stimulus queues expected results, a negedge monitor
// pops and compares them on every done pulse, also checking 20-cycle latency and done spacing.
module tb_div19sx8s;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [18:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [18:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;

    div19sx8s dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          acc;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   errors    = 0;
    int   checks    = 0;
    int   last_done = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d q=%h r=%h", cyc, quotient, remainder);
            end else begin
                e = sb.pop_front();
                checks++;
                if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz ||
                    ovf !== e.ov || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL result got q=%h r=%h dz=%b ovf=%b busy=%b, expected q=%h r=%h dz=%b ovf=%b busy=0",
                             quotient, remainder, div_zero, ovf, busy, e.q, e.r, e.dz, e.ov);
                end
                checks++;
                if (cyc - e.acc != 20) begin
                    errors++;
                    $display("FAIL latency got %0d expected 20 (q=%h)", cyc - e.acc, e.q);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_done != e.gap) begin
                        errors++;
                        $display("FAIL done_gap got %0d expected %0d", cyc - last_done, e.gap);
                    end
                end
            end
            last_done = cyc;
        end
    end

    // Caller is at a negedge with the divider idle; returns 1 time unit after the accepting edge.
    task automatic issue(input int a, input int b, input int eq, input int er,
                         input logic edz, input logic eov, input int gap);
        exp_t e;
        start    = 1'b1;
        dividend = a[18:0];
        divisor  = b[7:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q   = eq[18:0];
        e.r   = er[7:0];
        e.dz  = edz;
        e.ov  = eov;
        e.acc = cyc;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Returns at the negedge inside the done cycle.
    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no done within 40 cycles, expected one");
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({busy, done, quotient, remainder, div_zero, ovf} !== 31'd0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, expected all 0",
                     name, busy, done, quotient, remainder, div_zero, ovf);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 19'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        check_zero("reset_values");
        rst = 1'b0;

        // Leave a nonzero result held, then abort a second operation with reset.
        issue(1000, 7, 142, 6, 1'b0, 1'b0, 0);
        wait_done();
        issue(2000, 3, 666, 2, 1'b0, 1'b0, 21);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("reset_during_div");
        void'(sb.pop_back());
        rst = 1'b0;

        issue(1000, 7, 142, 6, 1'b0, 1'b0, 0);
        wait_done();
        issue(-1000, 7, -142, -6, 1'b0, 1'b0, 21);
        wait_done();
        issue(1000, -7, -142, 6, 1'b0, 1'b0, 21);
        wait_done();
        issue(-1000, -7, 142, -6, 1'b0, 1'b0, 0);
        wait_done();
        issue(-5, 7, 0, -5, 1'b0, 1'b0, 0);
        wait_done();

        issue(262143, -128, -2047, 127, 1'b0, 1'b0, 0);
        wait_done();
        issue(-262144, 1, -262144, 0, 1'b0, 1'b0, 0);
        wait_done();
        issue(-262144, -128, 2048, 0, 1'b0, 1'b0, 0);
        wait_done();

        issue(-262144, -1, 262143, 0, 1'b0, 1'b1, 0);
        wait_done();
        issue(1234, 0, 0, 0, 1'b1, 1'b0, 0);
        wait_done();
        issue(10, 3, 3, 1, 1'b0, 1'b0, 21);
        wait_done();

        issue(-130944, -128, 1023, 0, 1'b0, 1'b0, 0);
        wait_done();

        // Extra start pulses on edges 5 and 19 must be ignored.
        issue(500, 9, 55, 5, 1'b0, 1'b0, 21);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        dividend = 19'd100;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        start    = 1'b1;
        dividend = 19'd77;
        divisor  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        issue(-77, 5, -15, -2, 1'b0, 1'b0, 21);
        wait_done();

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_results got %0d outstanding, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div19sx8s.md
# div19sx8s

Sequential signed restoring divider: a 19-bit two's-complement dividend divided by an 8-bit two's-complement divisor gives a 19-bit quotient and an 8-bit remainder. It is the inverse companion of the 11x8 signed pipelined multiplier in the arithmetic datapath. A product from that multiplier can be divided back by either factor to recover the other, for checking or for normalisation. The block processes one operation at a time, one quotient bit per clock, under a start/busy/done handshake.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE.
- dividend  in  19  signed dividend, captured on the accepting edge.
- divisor  in  8  signed divisor, captured on the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse; result outputs valid from this cycle.
- quotient  out  19  signed quotient, truncated toward zero.
- remainder  out  8  signed remainder; takes the sign of the dividend.
- div_zero  out  1  divisor was 0 for this result.
- ovf  out  1  quotient not representable; saturated result.

## Operation
- Reset values: every output is 0, and the state is IDLE.
- The operation is truncating division: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
- Sign rules:
  - remainder sign = dividend sign, and 0 when the remainder is 0;
  - quotient is negative iff the operand signs differ and the quotient magnitude is nonzero.
- IDLE: on start=1, capture the operand magnitudes and signs.
  - |dividend| is 19 bits unsigned; -262144 maps to 19'h40000.
  - |divisor| is 8 bits unsigned; -128 maps to 8'h80.
  - Load the bit counter with 18, then go to DIV.
- DIV: one restoring step per cycle, MSB first, over 19 cycles.
  - Partial remainder r is 9 bits: r = {r[7:0], next dividend bit}.
  - If r ≥ |divisor|, subtract and shift in quotient bit 1; otherwise shift in 0.
  - After the count-0 step, go to FIX.
- FIX: apply sign correction, drive the result outputs, pulse done, return to IDLE.
- Divide by zero (divisor = 0): run through the normal states. The iteration result is discarded, and at FIX the outputs are quotient=0, remainder=0, div_zero=1, ovf=0.
- Overflow: the only case is dividend=-262144 with divisor=-1. At FIX the outputs are quotient=19'h3FFFF, remainder=0, ovf=1.
- div_zero and ovf are never both 1. Both are cleared at the next FIX that does not raise them.
- start while busy: ignored; operand inputs are not sampled.
- quotient, remainder and the flags hold their values from FIX until the next FIX or reset.

## Timing
- Edge 0 = the edge sampling start=1 in IDLE. busy is 1 after edge 0.
- DIV steps occur on edges 1..19. FIX updates the outputs on edge 20.
- After edge 20: done=1 and busy=0 for exactly one cycle, and the results are valid.
- Fixed latency of 20 cycles in all cases, including div_zero and ovf.
- start=1 in the done cycle is accepted, since the state is IDLE. A new operation can begin every 21 cycles.
- busy and done are never both 1.
- rst=1 on any edge forces IDLE and zeroes all outputs, including a result already held. rst has priority over start. An aborted operation produces no done.

## Test plan
- Reset: hold rst=1 during DIV → all outputs 0 and state IDLE on the next edge. Then assert start=1 with 1000/7 → done 20 cycles later, quotient=142, remainder=6.
- Signs: each case must complete in exactly 20 cycles.
  - -1000/7 → quotient=-142, remainder=-6.
  - 1000/-7 → quotient=-142, remainder=6.
  - -1000/-7 → quotient=142, remainder=-6.
  - -5/7 → quotient=0, remainder=-5.
- Extremes:
  - 262143/-128 → quotient=-2047, remainder=127.
  - -262144/1 → quotient=-262144, ovf=0.
  - -262144/-128 → quotient=2048, remainder=0.
- Exceptions:
  - -262144/-1 → quotient=19'h3FFFF, remainder=0, ovf=1.
  - 1234/0 → quotient=0, remainder=0, div_zero=1.
  - A following 10/3 clears both flags, with quotient=3, remainder=1.
- Round trip with the multiplier: dividend=-130944 (1023 × -128) with divisor=-128 → quotient=1023, remainder=0.
- Handshake:
  - Pulse start again at cycles 5 and 19 of an operation with different operands → ignored; the result matches the first operands.
  - Assert start in the done cycle → accepted; the second done arrives exactly 21 cycles after the first.
